// File: rtl/rvv_backend_div_array_if.sv
// Handshake and data bus between the DIV reservation station / ROB and the
// divider array.
//   in_valid/in_ready          : uop issue handshake
//   in_signed/in_rem           : signed mode, remainder select
//   in_a/in_b/in_tag           : dividend, divisor, opaque uop tag
//   out_valid/out_ready        : in-order result retire handshake
//   out_data/out_tag           : quotient or remainder, tag of retiring uop
// master = RS/ROB side, slave = divider array.
interface rvv_backend_div_array_if #(
  parameter int DW   = 32,
  parameter int TAGW = 5
) ();
  logic            in_valid;
  logic            in_ready;
  logic            in_signed;
  logic            in_rem;
  logic [DW-1:0]   in_a;
  logic [DW-1:0]   in_b;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [TAGW-1:0] out_tag;

  modport master (
    output in_valid, in_signed, in_rem, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_signed, in_rem, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/rvv_backend_div_array.sv
// Multi-lane iterative integer divider array for the RVV DIV path.
// Uops are accepted one per cycle and dispatched round-robin to NUM_LANE
// radix-2 restoring divider lanes; results retire strictly in issue order.
//   clk, rst   : clock, synchronous active-high reset
//   dif        : slave side of the issue/retire bus (see interface file)
//   lane_busy  : per-lane "not IDLE" status
module rvv_backend_div_array #(
  parameter int NUM_LANE = 2,
  parameter int DW       = 32,
  parameter int TAGW     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  rvv_backend_div_array_if.slave  dif,
  output logic [NUM_LANE-1:0]     lane_busy
);

  localparam int PW = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] INT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} lane_state_e;

  lane_state_e     state     [NUM_LANE];
  lane_state_e     state_nxt [NUM_LANE];
  logic [CW-1:0]   cnt       [NUM_LANE];
  logic [DW-1:0]   prem      [NUM_LANE];
  logic [DW-1:0]   quo       [NUM_LANE];
  logic [DW-1:0]   bmag      [NUM_LANE];
  logic [DW-1:0]   res       [NUM_LANE];
  logic [DW-1:0]   prem_nxt  [NUM_LANE];
  logic [DW-1:0]   quo_nxt   [NUM_LANE];
  logic [DW:0]     shifted   [NUM_LANE];
  logic [DW:0]     diff      [NUM_LANE];
  logic            neg_q     [NUM_LANE];
  logic            neg_r     [NUM_LANE];
  logic            sel_rem   [NUM_LANE];
  logic [TAGW-1:0] tag       [NUM_LANE];

  logic [PW-1:0]   issue_ptr;
  logic [PW-1:0]   retire_ptr;
  logic [DW-1:0]   hold_data;
  logic [TAGW-1:0] hold_tag;

  logic signed [DW-1:0] a_s;
  logic signed [DW-1:0] b_s;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic            ovf;
  logic            early;
  logic [DW-1:0]   early_res;
  logic            accept;
  logic            retire;

  function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_LANE - 1)) ? '0 : p + PW'(1);
  endfunction

  // Issue decode: operand signs and the two early-out cases
  assign a_s    = dif.in_a;
  assign b_s    = dif.in_b;
  assign a_neg  = dif.in_signed & a_s[DW-1];
  assign b_neg  = dif.in_signed & b_s[DW-1];
  assign b_zero = (dif.in_b == '0);
  assign ovf    = dif.in_signed & (dif.in_a == INT_MIN) & (&dif.in_b);
  assign early  = b_zero | ovf;

  always_comb begin
    early_res = '0;
    if (b_zero) early_res = dif.in_rem ? dif.in_a : '1;
    else        early_res = dif.in_rem ? '0 : dif.in_a;
  end

  // in_ready and out_valid look only at registered lane state, so a lane
  // freed by retire this cycle is not offered for issue until next cycle.
  assign dif.in_ready  = (state[issue_ptr] == IDLE);
  assign dif.out_valid = (state[retire_ptr] == DONE);
  assign dif.out_data  = dif.out_valid ? res[retire_ptr] : hold_data;
  assign dif.out_tag   = dif.out_valid ? tag[retire_ptr] : hold_tag;
  assign accept        = dif.in_valid & dif.in_ready;
  assign retire        = dif.out_valid & dif.out_ready;

  always_comb begin
    for (int i = 0; i < NUM_LANE; i++) lane_busy[i] = (state[i] != IDLE);
  end

  // One restoring step per lane: shift in the next dividend bit (MSB first)
  // and subtract the divisor magnitude if it fits.
  always_comb begin
    for (int i = 0; i < NUM_LANE; i++) begin
      shifted[i]  = {prem[i], quo[i][DW-1]};
      diff[i]     = shifted[i] - {1'b0, bmag[i]};
      prem_nxt[i] = shifted[i][DW-1:0];
      quo_nxt[i]  = {quo[i][DW-2:0], 1'b0};
      if (shifted[i] >= {1'b0, bmag[i]}) begin
        prem_nxt[i] = diff[i][DW-1:0];
        quo_nxt[i]  = {quo[i][DW-2:0], 1'b1};
      end
    end
  end

  // Lane FSM next state
  always_comb begin
    for (int i = 0; i < NUM_LANE; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        IDLE: if (accept && issue_ptr == PW'(i)) state_nxt[i] = early ? DONE : BUSY;
        BUSY: if (cnt[i] == CW'(DW - 1)) state_nxt[i] = DONE;
        DONE: if (retire && retire_ptr == PW'(i)) state_nxt[i] = IDLE;
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANE; i++) state[i] <= IDLE;
      issue_ptr  <= '0;
      retire_ptr <= '0;
      hold_data  <= '0;
      hold_tag   <= '0;
    end else begin
      for (int i = 0; i < NUM_LANE; i++) state[i] <= state_nxt[i];
      if (accept) issue_ptr  <= ptr_inc(issue_ptr);
      if (retire) retire_ptr <= ptr_inc(retire_ptr);
      // Remember what was last presented so the bus holds while idle.
      if (dif.out_valid) begin
        hold_data <= res[retire_ptr];
        hold_tag  <= tag[retire_ptr];
      end
    end
  end

  // Lane datapath: load on accept, iterate while BUSY, sign-fix on last step
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANE; i++) begin
      if (accept && issue_ptr == PW'(i)) begin
        tag[i]     <= dif.in_tag;
        sel_rem[i] <= dif.in_rem;
        cnt[i]     <= '0;
        prem[i]    <= '0;
        quo[i]     <= cond_neg(dif.in_a, a_neg);
        bmag[i]    <= cond_neg(dif.in_b, b_neg);
        neg_q[i]   <= a_neg ^ b_neg;
        neg_r[i]   <= a_neg;
        res[i]     <= early_res;
      end else if (state[i] == BUSY) begin
        prem[i] <= prem_nxt[i];
        quo[i]  <= quo_nxt[i];
        cnt[i]  <= cnt[i] + CW'(1);
        if (cnt[i] == CW'(DW - 1))
          res[i] <= sel_rem[i] ? cond_neg(prem_nxt[i], neg_r[i])
                               : cond_neg(quo_nxt[i], neg_q[i]);
      end
    end
  end

endmodule
